// File: rtl/tmr_pkg.sv
// tmr_pkg: shared constants, types and helpers for the triple-modular-redundancy lane monitor
package tmr_pkg;

   localparam int TMR_LANES = 3;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic [1:0] {IDLE, REQ, ACK} scrub_state_t;

   // Lowest-numbered failing lane wins when several fail together
   function automatic lane_idx_t first_lane(input logic [TMR_LANES-1:0] hit);
      return hit[0] ? 2'd0 : hit[1] ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/tmr_majority_voter.sv
// tmr_majority_voter: bitwise 2-of-3 vote plus per-lane disagreement flags
module tmr_majority_voter #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   output logic [WIDTH-1:0] maj_o,
   output logic [2:0]       mismatch_o
);

   assign maj_o      = (a_i & b_i) | (b_i & c_i) | (c_i & a_i);
   assign mismatch_o = {|(c_i ^ maj_o), |(b_i ^ maj_o), |(a_i ^ maj_o)};

endmodule

// File: rtl/tmr_lane_monitor.sv
// tmr_lane_monitor: votes three replica lanes, tracks per-lane errors and requests scrubs of failing lanes
module tmr_lane_monitor
   import tmr_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int CNT_W       = 8,
   parameter int FAIL_THRESH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             port_valid,
   input  logic [WIDTH-1:0] port_in_0,
   input  logic [WIDTH-1:0] port_in_1,
   input  logic [WIDTH-1:0] port_in_2,
   output logic [WIDTH-1:0] port_out,
   output logic             out_valid,
   output logic [2:0]       mismatch,
   output logic             uncorrectable,
   output logic [CNT_W-1:0] err_cnt_0,
   output logic [CNT_W-1:0] err_cnt_1,
   output logic [CNT_W-1:0] err_cnt_2,
   input  logic             clear_cnt,
   output logic             scrub_req,
   output logic [1:0]       scrub_lane,
   input  logic             scrub_ack
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THR     = CNT_W'(FAIL_THRESH);

   logic [WIDTH-1:0]     in0_q, in1_q, in2_q, out_q, maj_d;
   logic                 valid_q, out_valid_q, unc_q, ack_clr;
   logic [2:0]           mis_d, mis_q;
   logic [CNT_W-1:0]     err_cnt_q [TMR_LANES];
   logic [CNT_W-1:0]     err_cnt_d [TMR_LANES];
   logic [CNT_W-1:0]     consec_q  [TMR_LANES];
   logic [CNT_W-1:0]     consec_d  [TMR_LANES];
   logic [TMR_LANES-1:0] hit;
   scrub_state_t         state_q, state_d;
   lane_idx_t            scrub_lane_q;

   tmr_majority_voter #(.WIDTH(WIDTH)) u_voter (
      .a_i       (in0_q),
      .b_i       (in1_q),
      .c_i       (in2_q),
      .maj_o     (maj_d),
      .mismatch_o(mis_d)
   );

   // Stage 1: capture the raw lanes and their valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         in0_q   <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
      end else begin
         valid_q <= port_valid;
         in0_q   <= port_in_0;
         in1_q   <= port_in_1;
         in2_q   <= port_in_2;
      end
   end

   // Stage 2: register the vote and flags; they hold between valid samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         mis_q       <= '0;
         unc_q       <= 1'b0;
      end else begin
         out_valid_q <= valid_q;
         if (valid_q) begin
            out_q <= maj_d;
            mis_q <= mis_d;
            unc_q <= (mis_d[0] & mis_d[1]) | (mis_d[1] & mis_d[2]) | (mis_d[0] & mis_d[2]);
         end
      end
   end

   // Counter next-state: clear beats scrub-ack clear beats sample update; idle cycles hold
   always_comb begin
      ack_clr = (state_q == REQ) && scrub_ack;
      for (int i = 0; i < TMR_LANES; i++) begin
         hit[i]       = consec_q[i] == THR;
         err_cnt_d[i] = clear_cnt ? '0 :
                        (valid_q && mis_d[i] && err_cnt_q[i] != CNT_MAX) ? err_cnt_q[i] + 1'b1 : err_cnt_q[i];
         consec_d[i]  = clear_cnt ? '0 :
                        (ack_clr && scrub_lane_q == lane_idx_t'(i)) ? '0 :
                        !valid_q ? consec_q[i] :
                        !mis_d[i] ? '0 :
                        hit[i] ? THR : consec_q[i] + 1'b1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TMR_LANES; i++) begin
            err_cnt_q[i] <= '0;
            consec_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < TMR_LANES; i++) begin
            err_cnt_q[i] <= err_cnt_d[i];
            consec_q[i]  <= consec_d[i];
         end
      end
   end

   // Scrub FSM state register, with the served lane latched on entry to REQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         scrub_lane_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && |hit) scrub_lane_q <= first_lane(hit);
      end
   end

   // Scrub FSM next state: ACK always lasts one cycle so requests are separated by an idle cycle
   always_comb begin
      state_d = (state_q == IDLE) ? (|hit ? REQ : IDLE) :
                (state_q == REQ)  ? (scrub_ack ? ACK : REQ) : IDLE;
   end

   // Scrub FSM outputs
   always_comb begin
      scrub_req = state_q == REQ;
   end

   assign port_out      = out_q;
   assign out_valid     = out_valid_q;
   assign mismatch      = mis_q;
   assign uncorrectable = unc_q;
   assign err_cnt_0     = err_cnt_q[0];
   assign err_cnt_1     = err_cnt_q[1];
   assign err_cnt_2     = err_cnt_q[2];
   assign scrub_lane    = scrub_lane_q;

endmodule

// File: tb/tb_tmr_lane_monitor.sv
// tb_tmr_lane_monitor: table, directed and random checks of two monitor configurations against a reference model
module tb_tmr_lane_monitor;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       port_valid = 1'b0, clear_cnt = 1'b0, scrub_ack = 1'b0;
   logic [7:0] in0 = '0, in1 = '0, in2 = '0;
   logic [7:0] out_a, out_b, e0a, e1a, e2a;
   logic [1:0] e0b, e1b, e2b, ln_a, ln_b;
   logic [2:0] mis_a, mis_b;
   logic       ov_a, ov_b, unc_a, unc_b, req_a, req_b;

   always #5 clk = ~clk;

   tmr_lane_monitor #(.WIDTH(8), .CNT_W(8), .FAIL_THRESH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .port_valid(port_valid),
      .port_in_0(in0), .port_in_1(in1), .port_in_2(in2),
      .port_out(out_a), .out_valid(ov_a), .mismatch(mis_a), .uncorrectable(unc_a),
      .err_cnt_0(e0a), .err_cnt_1(e1a), .err_cnt_2(e2a), .clear_cnt(clear_cnt),
      .scrub_req(req_a), .scrub_lane(ln_a), .scrub_ack(scrub_ack)
   );

   tmr_lane_monitor #(.WIDTH(8), .CNT_W(2), .FAIL_THRESH(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .port_valid(port_valid),
      .port_in_0(in0), .port_in_1(in1), .port_in_2(in2),
      .port_out(out_b), .out_valid(ov_b), .mismatch(mis_b), .uncorrectable(unc_b),
      .err_cnt_0(e0b), .err_cnt_1(e1b), .err_cnt_2(e2b), .clear_cnt(clear_cnt),
      .scrub_req(req_b), .scrub_lane(ln_b), .scrub_ack(scrub_ack)
   );

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: index d=0 is dut_a, d=1 is dut_b; FSM phase 0=idle 1=requesting 2=acked
   int         thr [2] = '{4, 3};
   int         cmax[2] = '{255, 3};
   logic [7:0] pl[3];
   bit         pv;
   logic [7:0] m_out;
   bit         m_ov, m_unc;
   bit   [2:0] m_mis;
   int         m_err[2][3], m_con[2][3], m_st[2], m_lane[2];

   function automatic void model_reset();
      pv = 0; m_ov = 0; m_unc = 0; m_mis = 0; m_out = 0;
      for (int i = 0; i < 3; i++) pl[i] = 0;
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0; m_lane[d] = 0;
         for (int i = 0; i < 3; i++) begin m_err[d][i] = 0; m_con[d][i] = 0; end
      end
   endfunction

   function automatic void model_edge();
      logic [7:0] maj = '0;
      bit   [2:0] mis = '0;
      if (pv) begin
         for (int b = 0; b < 8; b++) maj[b] = (int'(pl[0][b]) + int'(pl[1][b]) + int'(pl[2][b])) >= 2;
         for (int i = 0; i < 3; i++) mis[i] = pl[i] != maj;
         m_out = maj; m_mis = mis; m_unc = $countones(mis) >= 2;
      end
      m_ov = pv;
      for (int d = 0; d < 2; d++) begin
         bit ack_clr = (m_st[d] == 1) && scrub_ack;
         int served  = m_lane[d];
         if (m_st[d] == 0) begin
            for (int i = 2; i >= 0; i--) if (m_con[d][i] == thr[d]) begin m_st[d] = 1; m_lane[d] = i; end
         end else if (m_st[d] == 1) begin
            if (scrub_ack) m_st[d] = 2;
         end else m_st[d] = 0;
         for (int i = 0; i < 3; i++) begin
            if (clear_cnt) begin
               m_err[d][i] = 0; m_con[d][i] = 0;
            end else begin
               if (pv && mis[i] && m_err[d][i] < cmax[d]) m_err[d][i]++;
               if (ack_clr && i == served) m_con[d][i] = 0;
               else if (pv) m_con[d][i] = mis[i] ? (m_con[d][i] < thr[d] ? m_con[d][i] + 1 : thr[d]) : 0;
            end
         end
      end
      pl[0] = in0; pl[1] = in1; pl[2] = in2; pv = port_valid;
   endfunction

   task automatic compare_all();
      check("out_valid_a", ov_a, m_ov);
      check("out_valid_b", ov_b, m_ov);
      if (m_ov) begin
         check("port_out_a", out_a, m_out);
         check("port_out_b", out_b, m_out);
         check("mismatch_a", mis_a, m_mis);
         check("mismatch_b", mis_b, m_mis);
         check("uncorr_a", unc_a, m_unc);
         check("uncorr_b", unc_b, m_unc);
      end
      check("err0_a", e0a, m_err[0][0]);
      check("err1_a", e1a, m_err[0][1]);
      check("err2_a", e2a, m_err[0][2]);
      check("err0_b", e0b, m_err[1][0]);
      check("err1_b", e1b, m_err[1][1]);
      check("err2_b", e2b, m_err[1][2]);
      check("scrub_req_a", req_a, m_st[0] == 1);
      check("scrub_req_b", req_b, m_st[1] == 1);
      if (m_st[0] == 1) check("scrub_lane_a", ln_a, m_lane[0]);
      if (m_st[1] == 1) check("scrub_lane_b", ln_b, m_lane[1]);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit v, input logic [7:0] a, b, c, input bit clr, ack);
      port_valid = v; in0 = a; in1 = b; in2 = c; clear_cnt = clr; scrub_ack = ack;
   endtask

   task automatic flush();
      drive(0, 0, 0, 0, 1, 1); cyc();
      drive(0, 0, 0, 0, 0, 0); repeat (3) cyc();
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!req_a && n < 10) begin cyc(); n++; end
      check(name, req_a, 1);
   endtask

   typedef struct {
      logic [7:0] l0, l1, l2, out;
      logic [2:0] mis;
      logic       unc;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 3'b000, 1'b0};
      tbl[1] = '{8'hF0, 8'h0F, 8'hFF, 8'hFF, 3'b011, 1'b1};
      tbl[2] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 3'b001, 1'b0};
      tbl[3] = '{8'h12, 8'h34, 8'h12, 8'h12, 3'b010, 1'b0};
      tbl[4] = '{8'h0F, 8'hF0, 8'h00, 8'h00, 3'b011, 1'b1};
      tbl[5] = '{8'hFF, 8'h00, 8'h0F, 8'h0F, 3'b011, 1'b1};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_port_out", out_a, 0);
      check("reset_mismatch", mis_a, 0);
      compare_all();
      rst_n = 1'b1;
      cyc();
      // Single-sample vectors with fixed expected vote results
      foreach (tbl[k]) begin
         drive(1, tbl[k].l0, tbl[k].l1, tbl[k].l2, 0, 0); cyc();
         drive(0, 0, 0, 0, 0, 0); cyc();
         check("tbl_port_out", out_a, tbl[k].out);
         check("tbl_mismatch", mis_a, tbl[k].mis);
         check("tbl_uncorr", unc_a, tbl[k].unc);
      end
      flush();
      // Lane 1 wrong for three samples
      drive(1, 8'hFF, 8'h00, 8'hFF, 0, 0); repeat (3) cyc();
      drive(0, 0, 0, 0, 0, 0); repeat (2) cyc();
      check("t2_err1", e1a, 3);
      check("t2_err0", e0a, 0);
      check("t2_mis", mis_a, 3'b010);
      flush();
      // Lane 2 fails four times, request held five cycles then acknowledged
      drive(1, 8'hFF, 8'hFF, 8'h00, 0, 0); repeat (4) cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
      wait_req("t3_req_seen");
      check("t3_lane", ln_a, 2);
      repeat (5) cyc();
      drive(0, 0, 0, 0, 0, 1); cyc();
      drive(0, 0, 0, 0, 0, 0);
      check("t3_req_dropped", req_a, 0);
      check("t3_err2_kept", e2a, 4);
      repeat (3) cyc();
      check("t3_no_rerequest", req_a, 0);
      flush();
      // Small counter saturates, then clear beats a coincident increment
      drive(1, 8'h00, 8'hFF, 8'hFF, 0, 0); repeat (6) cyc();
      drive(0, 0, 0, 0, 0, 0); repeat (2) cyc();
      check("t5_sat", e0b, 3);
      drive(1, 8'h00, 8'hFF, 8'hFF, 0, 0); cyc();
      drive(0, 0, 0, 0, 1, 0); cyc();
      check("t5_clear_b", e0b, 0);
      check("t5_clear_a", e0a, 0);
      flush();
      // Lanes 0 and 2 fail together: lane 0 served first, lane 2 after an idle cycle
      drive(1, 8'h0F, 8'h00, 8'hF0, 0, 0); repeat (4) cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
      wait_req("t6_first_req");
      check("t6_first_lane", ln_a, 0);
      drive(0, 0, 0, 0, 0, 1); cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
      check("t6_idle_gap", req_a, 0);
      wait_req("t6_second_req");
      check("t6_second_lane", ln_a, 2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_rst_req", req_a, 0);
      check("t6_rst_err0", e0a, 0);
      compare_all();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) cyc();
      // Random traffic with a roaming bad lane
      for (int n = 0; n < 600; n++) begin
         logic [7:0] base, l[3];
         int bad;
         base = 8'($urandom);
         bad  = (n / 40) % 3;
         for (int i = 0; i < 3; i++) begin
            l[i] = base;
            if ((i == bad && $urandom_range(0, 9) < 7) || $urandom_range(0, 15) == 0) l[i] = base ^ 8'($urandom_range(1, 255));
         end
         drive($urandom_range(0, 9) < 8, l[0], l[1], l[2], $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
